nibble_serial_adder: RTL
========================

// Module: nibble_serial_adder
// PURPOSE
//   Multi-cycle WIDTH-bit adder built around the team's combinational 4-bit `adder`
//   (a,b,cin -> sum,cout). Accepts one operand pair over a valid/ready handshake,
//   drives `adder` one nibble per clock (LSB nibble first), chains the carry in a register,
//   and presents the full sum/carry-out downstream over a second valid/ready handshake.
// PARAMETERS
//   WIDTH    16   operand/result width; must be a multiple of 4 and >= 4 (elaboration error otherwise)
//   NIBBLES  WIDTH/4  derived localparam; number of RUN cycles per operation
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      upstream operand pair valid
//   in_ready   out  1      block can accept an operand pair (high only in IDLE)
//   in_a       in   WIDTH  operand A, unsigned
//   in_b       in   WIDTH  operand B, unsigned
//   in_cin     in   1      initial carry-in
//   out_valid  out  1      result valid (high only in DONE)
//   out_ready  in   1      downstream accepts result
//   out_sum    out  WIDTH  registered sum
//   out_cout   out  1      registered carry-out of bit WIDTH-1
//   busy       out  1      high in RUN or DONE
//   out_ovf    out  1      signed overflow flag; present only with NSA_OVERFLOW_EN
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; out_valid=0, out_sum=0, out_cout=0, busy=0,
//     out_ovf=0, carry reg=0, nibble index=0; in_ready=1 (IDLE). Reset mid-RUN/DONE abandons op.
//   - FSM: IDLE -> RUN on in_valid&&in_ready (latch in_a, in_b, carry<=in_cin, idx<=0).
//     RUN: each cycle feed a[4*idx+:4], b[4*idx+:4], carry to `adder`; write sum nibble into
//     result[4*idx+:4]; carry<=cout; idx<=idx+1. When idx==NIBBLES-1 -> DONE, out_cout<=cout.
//     DONE: out_valid=1; on out_ready -> IDLE. No other transitions.
//   - Latency: out_valid rises exactly NIBBLES clocks after the accepting edge (4 for WIDTH=16).
//   - Throughput: no overlap; in_ready low in RUN and DONE, so next accept is no earlier than
//     the cycle after the out handshake. Minimum NIBBLES+2 cycles per op with out_ready held high.
//   - in_valid while in_ready=0 is ignored (no capture, no error); operands held internally,
//     so upstream may change in_a/in_b after the accept edge.
//   - out_sum/out_cout/out_ovf stable for the whole time out_valid=1; they retain the last
//     result after returning to IDLE (not cleared) until overwritten by the next op.
//   - out_sum built in a staging register; out_sum register updated only on RUN->DONE, never
//     exposes partial nibbles.
//   - Arithmetic: {out_cout,out_sum} == in_a + in_b + in_cin, modulo 2^(WIDTH+1). idx width
//     $clog2(NIBBLES), minimum 1.
// CONFIGURATION
//   NSA_OVERFLOW_EN defined: out_ovf port exists; on RUN->DONE out_ovf <= a[W-1]^b[W-1]
//     ^sum[W-1]^cout (carry into MSB xor carry out), i.e. two's-complement overflow.
//   Not defined: out_ovf port absent, no overflow logic; all other behaviour identical.
// STRUCTURE
//   - Package nsa_pkg: NIBBLE_W=4 constant; state encoding localparams IDLE=2'd0, RUN=2'd1,
//     DONE=2'd2 (2'd3 unreachable, decodes to IDLE).
//   - One sub-module: existing `adder`, instantiated once, driven by mux of current nibble.
//   - Control FSM, idx counter, carry reg, operand/staging/output registers in this module.
// TESTING  (WIDTH=16)
//   1. Reset then release, no input -> out_valid=0, out_sum=16'h0000, out_cout=0, busy=0, in_ready=1.
//   2. 16'h1234 + 16'h4321, cin=0, out_ready=1 -> out_sum=16'h5555, cout=0; out_valid exactly
//      4 clocks after accept, single-cycle pulse.
//   3. 16'hFFFF + 16'h0001, cin=0 -> out_sum=16'h0000, cout=1 (carry ripples all 4 nibbles);
//      16'hFFFF + 16'hFFFF, cin=1 -> out_sum=16'hFFFF, cout=1.
//   4. Backpressure: 16'h00FF + 16'h0001 with out_ready=0 for 5 cycles -> out_valid,
//      out_sum=16'h0100 held; in_ready=0; new in_valid pair ignored; accepted after out_ready=1.
//   5. Reset asserted 2 cycles into RUN -> all outputs at reset values immediately; next op
//      16'h0008 + 16'h0008, cin=1 -> out_sum=16'h0011, cout=0.
//   6. NSA_OVERFLOW_EN: 16'h7FFF + 16'h0001 -> out_ovf=1, out_sum=16'h8000; 16'h8000 + 16'h8000 ->
//      out_ovf=1, cout=1, out_sum=0; 16'h0001 + 16'h0001 -> out_ovf=0. Random 1000 ops vs a+b+cin.

Source files
------------

// File: rtl/nsa_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial adder.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_adder.sv
// Combinational 4-bit adder slice used one nibble per clock by nibble_serial_adder.
module adder
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    // Plain ripple add of one nibble plus carry.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a shared 4-bit adder.
// Optional signed-overflow output out_ovf is enabled by defining NSA_OVERFLOW_EN.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
`ifdef NSA_OVERFLOW_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t                state_r;
    logic [IDX_W-1:0]      idx_r;
    logic                  carry_r;
    logic [WIDTH-1:0]      a_r;
    logic [WIDTH-1:0]      b_r;
    logic [WIDTH-1:0]      stage_r;
    logic [NIBBLE_W-1:0]   nib_a_s;
    logic [NIBBLE_W-1:0]   nib_b_s;
    logic [NIBBLE_W-1:0]   nib_sum_s;
    logic                  nib_cout_s;
    logic [WIDTH-1:0]      sum_next_s;

    // Select the operand nibbles addressed by the current index.
    always_comb begin
        nib_a_s = a_r[NIBBLE_W*idx_r +: NIBBLE_W];
        nib_b_s = b_r[NIBBLE_W*idx_r +: NIBBLE_W];
    end

    adder u_adder (
        .a    (nib_a_s),
        .b    (nib_b_s),
        .cin  (carry_r),
        .sum  (nib_sum_s),
        .cout (nib_cout_s)
    );

    // Staging value with the current nibble merged in, so the final nibble reaches out_sum directly.
    always_comb begin
        sum_next_s = stage_r;
        sum_next_s[NIBBLE_W*idx_r +: NIBBLE_W] = nib_sum_s;
    end

    // Handshake status is a direct decode of the state register.
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r == RUN) || (state_r == DONE);

    // Control FSM with operand, carry, index, staging and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            idx_r    <= '0;
            carry_r  <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            stage_r  <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
`ifdef NSA_OVERFLOW_EN
            out_ovf  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= in_a;
                        b_r     <= in_b;
                        carry_r <= in_cin;
                        idx_r   <= '0;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    stage_r <= sum_next_s;
                    carry_r <= nib_cout_s;
                    if (idx_r == LAST_IDX) begin
                        idx_r    <= '0;
                        out_sum  <= sum_next_s;
                        out_cout <= nib_cout_s;
`ifdef NSA_OVERFLOW_EN
                        // Carry into the MSB xor carry out of it.
                        out_ovf  <= a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ nib_sum_s[NIBBLE_W-1] ^ nib_cout_s;
`endif
                        state_r  <= DONE;
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1);
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
